// File: rtl/crack_pkg.sv
// Shared types and constants for the ARC4 key-search controller.
package crack_pkg;

    localparam int unsigned KEY_W  = 24;
    localparam int unsigned ADDR_W = 8;

    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    typedef enum logic [3:0] {
        IDLE,
        LAUNCH,
        DECRYPT,
        LEN_RD,
        LEN_CHK,
        BYTE_RD,
        BYTE_CHK,
        NEXT,
        DONE
    } crack_state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/crack_ctrl_if.sv
// Datapath bus between crack_ctrl (master) and the arc4 core / plaintext memory (slave).
interface crack_ctrl_if;
    import crack_pkg::*;

    logic              arc_en;
    logic              arc_rdy;
    logic [KEY_W-1:0]  arc_key;
    logic [ADDR_W-1:0] pt_addr;
    logic [7:0]        pt_rddata;

    modport master (
        output arc_en, arc_key, pt_addr,
        input  arc_rdy, pt_rddata
    );

    modport slave (
        input  arc_en, arc_key, pt_addr,
        output arc_rdy, pt_rddata
    );

endinterface

// File: rtl/pt_scanner.sv
// Reads the length-prefixed plaintext and reports whether every byte is printable ASCII.
module pt_scanner
    import crack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        pt_rddata,
    output logic [ADDR_W-1:0] pt_addr,
    output logic              done,
    output logic              ok
);

    crack_state_t      state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
        end
    end

    // The registered read address doubles as the byte index i.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        done    = 1'b0;
        ok      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    state_d = LEN_RD;
                end
            end
            LEN_RD:  state_d = LEN_CHK;
            LEN_CHK: begin
                len_d = pt_rddata;
                if (pt_rddata == '0) begin
                    done    = 1'b1;
                    ok      = 1'b1;
                    state_d = IDLE;
                end else begin
                    addr_d  = 8'd1;
                    state_d = BYTE_RD;
                end
            end
            BYTE_RD: state_d = BYTE_CHK;
            BYTE_CHK: begin
                if (!is_printable(pt_rddata)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (addr_q == len_q) begin
                    done    = 1'b1;
                    ok      = 1'b1;
                    state_d = IDLE;
                end else begin
                    addr_d  = addr_q + 8'd1;
                    state_d = BYTE_RD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pt_addr = addr_q;

endmodule

// File: rtl/crack_ctrl.sv
// ARC4 key-search controller: sequences candidate keys through arc4 and scans the plaintext.
// Optional CRACK_KEYCNT_EN adds the key_cnt output counting keys launched per search.
module crack_ctrl
    import crack_pkg::*;
#(
    parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
    parameter logic [KEY_W-1:0] KEY_STEP  = 24'h000001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             rdy,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    crack_ctrl_if.master     bus
`ifdef CRACK_KEYCNT_EN
    ,
    output logic [KEY_W-1:0] key_cnt
`endif
);

    crack_state_t      state_q, state_d;
    logic              rdy_q, rdy_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              kv_q, kv_d;
    logic              arc_en_q, arc_en_d;
    logic [KEY_W-1:0]  arc_key_q, arc_key_d;
    logic [KEY_W:0]    sum;
    logic              scan_start, scan_done, scan_ok;
    logic [ADDR_W-1:0] scan_addr;

    pt_scanner u_scanner (
        .clk       (clk),
        .rst       (rst),
        .start     (scan_start),
        .pt_rddata (bus.pt_rddata),
        .pt_addr   (scan_addr),
        .done      (scan_done),
        .ok        (scan_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rdy_q     <= 1'b1;
            key_q     <= '0;
            kv_q      <= 1'b0;
            arc_en_q  <= 1'b0;
            arc_key_q <= KEY_START;
        end else begin
            state_q   <= state_d;
            rdy_q     <= rdy_d;
            key_q     <= key_d;
            kv_q      <= kv_d;
            arc_en_q  <= arc_en_d;
            arc_key_q <= arc_key_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        kv_d       = kv_q;
        arc_en_d   = 1'b0;
        arc_key_d  = arc_key_q;
        scan_start = 1'b0;
        sum        = {1'b0, arc_key_q} + {1'b0, KEY_STEP};
        case (state_q)
            IDLE, DONE: begin
                if (en) begin
                    kv_d      = 1'b0;
                    arc_key_d = KEY_START;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                if (bus.arc_rdy) begin
                    arc_en_d = 1'b1;
                    state_d  = DECRYPT;
                end
            end
            // arc_en_q is high only in the first DECRYPT cycle, before arc4 drops rdy.
            DECRYPT: begin
                if (!arc_en_q && bus.arc_rdy) begin
                    scan_start = 1'b1;
                    state_d    = LEN_RD;
                end
            end
            // LEN_RD..BYTE_CHK are walked inside pt_scanner; this level parks in LEN_RD.
            LEN_RD: begin
                if (scan_done) begin
                    if (scan_ok) begin
                        key_d   = arc_key_q;
                        kv_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                if (sum[KEY_W]) begin
                    kv_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    arc_key_d = sum[KEY_W-1:0];
                    state_d   = LAUNCH;
                end
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE) || (state_d == DONE);
    end

`ifdef CRACK_KEYCNT_EN
    logic [KEY_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (rdy_q && en) begin
            cnt_q <= '0;
        end else if (arc_en_q && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 24'd1;
        end
    end

    assign key_cnt = cnt_q;
`endif

    assign rdy         = rdy_q;
    assign key         = key_q;
    assign key_valid   = kv_q;
    assign bus.arc_en  = arc_en_q;
    assign bus.arc_key = arc_key_q;
    assign bus.pt_addr = scan_addr;

endmodule

// File: tb/tb_crack_ctrl.sv
// Directed bench for crack_ctrl with a behavioural arc4 core and plaintext memory per instance.
module tb_crack_ctrl;
    import crack_pkg::*;

    localparam int unsigned ARC_LAT = 4;
    localparam int unsigned BUDGET  = 2000;

    logic clk = 1'b0;
    logic rst, en0, en1;
    always #5 clk = ~clk;

    crack_ctrl_if bus0 ();
    crack_ctrl_if bus1 ();

    logic        rdy0, kv0, rdy1, kv1;
    logic [23:0] key0, key1;
`ifdef CRACK_KEYCNT_EN
    logic [23:0] cnt0, cnt1;
`endif

    crack_ctrl #(.KEY_START(24'h1E45F0), .KEY_STEP(24'h000001)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .en        (en0),
        .rdy       (rdy0),
        .key       (key0),
        .key_valid (kv0),
        .bus       (bus0)
`ifdef CRACK_KEYCNT_EN
        ,
        .key_cnt   (cnt0)
`endif
    );

    crack_ctrl #(.KEY_START(24'hFFFFF0), .KEY_STEP(24'h000001)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .en        (en1),
        .rdy       (rdy1),
        .key       (key1),
        .key_valid (kv1),
        .bus       (bus1)
`ifdef CRACK_KEYCNT_EN
        ,
        .key_cnt   (cnt1)
`endif
    );

    // Plaintext contents: good_key and alt_key decrypt to their messages, any other key
    // yields length 5 with a non-printable first byte.
    logic [23:0] good_key = 24'h000000;
    logic [23:0] alt_key  = 24'h000000;
    logic [7:0]  good_msg [0:7];
    logic [7:0]  alt_msg  [0:7];
    logic        block0 = 1'b0;

    function automatic logic [7:0] mem_byte(input logic [23:0] k, input logic [7:0] a);
        if (k == good_key) return (a < 8'd8) ? good_msg[a[2:0]] : 8'h41;
        if (k == alt_key)  return (a < 8'd8) ? alt_msg[a[2:0]]  : 8'h41;
        if (a == 8'd0) return 8'd5;
        if (a == 8'd1) return 8'h01;
        return 8'h41;
    endfunction

    logic [23:0] mk0 = '0, mk1 = '0;
    int unsigned busy0 = 0, busy1 = 0;

    always @(posedge clk) begin
        if (bus0.arc_en) begin
            mk0   <= bus0.arc_key;
            busy0 <= ARC_LAT;
        end else if (busy0 != 0) begin
            busy0 <= busy0 - 1;
        end
        bus0.pt_rddata <= mem_byte(mk0, bus0.pt_addr);
    end
    assign bus0.arc_rdy = (busy0 == 0) && !block0;

    always @(posedge clk) begin
        if (bus1.arc_en) begin
            mk1   <= bus1.arc_key;
            busy1 <= ARC_LAT;
        end else if (busy1 != 0) begin
            busy1 <= busy1 - 1;
        end
        bus1.pt_rddata <= mem_byte(mk1, bus1.pt_addr);
    end
    assign bus1.arc_rdy = (busy1 == 0);

    int unsigned pulses0 = 0, pulses1 = 0, dbl0 = 0;
    logic        prev_en0 = 1'b0;

    always @(posedge clk) begin
        if (bus0.arc_en) pulses0 <= pulses0 + 1;
        if (bus0.arc_en && prev_en0) dbl0 <= dbl0 + 1;
        prev_en0 <= bus0.arc_en;
        if (bus1.arc_en) pulses1 <= pulses1 + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rdy(input int which, input string tag);
        int unsigned n = 0;
        while (((which == 0) ? rdy0 : rdy1) !== 1'b1 && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_timeout"}, {31'd0, (which == 0) ? rdy0 : rdy1}, 32'd1);
    endtask

    task automatic run0(input string tag);
        en0 = 1'b1;
        @(posedge clk);
        #1;
        en0 = 1'b0;
        wait_rdy(0, tag);
    endtask

    int unsigned base;

    initial begin
        rst = 1'b1;
        en0 = 1'b0;
        en1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            good_msg[i] = 8'h00;
            alt_msg[i]  = 8'h00;
        end

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy",      {31'd0, rdy0}, 32'd1);
        check("rst_kv",       {31'd0, kv0}, 32'd0);
        check("rst_arc_en",   {31'd0, bus0.arc_en}, 32'd0);
        check("rst_arc_key",  {8'd0, bus0.arc_key}, 32'h1E45F0);
        check("rst_key",      {8'd0, key0}, 32'd0);
        check("rst_pt_addr",  {24'd0, bus0.pt_addr}, 32'd0);
        check("rst_arc_key1", {8'd0, bus1.arc_key}, 32'hFFFFF0);
`ifdef CRACK_KEYCNT_EN
        check("rst_key_cnt",  {8'd0, cnt0}, 32'd0);
`endif
        rst = 1'b0;

        // Find key 1E4600 after 17 launches, with a stray en while busy
        good_key = 24'h1E4600;
        good_msg = '{8'd5, "h", "e", "l", "l", "o", 8'h00, 8'h00};
        base = pulses0;
        en0 = 1'b1;
        @(posedge clk);
        #1;
        en0 = 1'b0;
        check("accept_rdy_low",  {31'd0, rdy0}, 32'd0);
        check("accept_no_arcen", {31'd0, bus0.arc_en}, 32'd0);
        @(posedge clk);
        #1;
        check("first_arc_en",    {31'd0, bus0.arc_en}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        en0 = 1'b1;
        @(posedge clk);
        #1;
        en0 = 1'b0;
        check("busy_en_ignored", {31'd0, rdy0}, 32'd0);
        wait_rdy(0, "find");
        check("find_key",    {8'd0, key0}, 32'h1E4600);
        check("find_kv",     {31'd0, kv0}, 32'd1);
        check("find_pulses", pulses0 - base, 32'd17);
`ifdef CRACK_KEYCNT_EN
        check("find_key_cnt", {8'd0, cnt0}, 32'd17);
`endif

        // Exhaustion on the second instance: no wrap past FFFFFF
        base = pulses1;
        en1 = 1'b1;
        @(posedge clk);
        #1;
        en1 = 1'b0;
        wait_rdy(1, "exhaust");
        check("exhaust_kv",      {31'd0, kv1}, 32'd0);
        check("exhaust_arc_key", {8'd0, bus1.arc_key}, 32'hFFFFFF);
        check("exhaust_pulses",  pulses1 - base, 32'd16);

        // Character bounds
        good_key = 24'h1E45F0;
        alt_key  = 24'h1E45F1;
        alt_msg  = '{8'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        good_msg = '{8'd3, "a", "b", 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
        base = pulses0;
        run0("lo_edge");
        check("lo_edge_key",    {8'd0, key0}, 32'h1E45F0);
        check("lo_edge_kv",     {31'd0, kv0}, 32'd1);
        check("lo_edge_pulses", pulses0 - base, 32'd1);

        good_msg = '{8'd3, "a", "b", 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00};
        base = pulses0;
        run0("hi_edge");
        check("hi_edge_key",    {8'd0, key0}, 32'h1E45F0);
        check("hi_edge_pulses", pulses0 - base, 32'd1);

        good_msg = '{8'd3, "a", "b", 8'h1F, 8'h00, 8'h00, 8'h00, 8'h00};
        base = pulses0;
        run0("below_lo");
        check("below_lo_key",    {8'd0, key0}, 32'h1E45F1);
        check("below_lo_kv",     {31'd0, kv0}, 32'd1);
        check("below_lo_pulses", pulses0 - base, 32'd2);

        good_msg = '{8'd3, "a", "b", 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
        base = pulses0;
        run0("above_hi");
        check("above_hi_key",    {8'd0, key0}, 32'h1E45F1);
        check("above_hi_pulses", pulses0 - base, 32'd2);

        good_msg = '{8'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        alt_key  = 24'h000000;
        base = pulses0;
        run0("len0");
        check("len0_key",    {8'd0, key0}, 32'h1E45F0);
        check("len0_kv",     {31'd0, kv0}, 32'd1);
        check("len0_pulses", pulses0 - base, 32'd1);

        // Reset while the scanner is in BYTE_CHK
        good_key = 24'h000000;
        en0 = 1'b1;
        @(posedge clk);
        #1;
        en0 = 1'b0;
        begin
            int unsigned n = 0;
            while (bus0.pt_addr !== 8'd1 && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("midscan_reached", {24'd0, bus0.pt_addr}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midscan_rdy",     {31'd0, rdy0}, 32'd1);
        check("midscan_kv",      {31'd0, kv0}, 32'd0);
        check("midscan_arc_en",  {31'd0, bus0.arc_en}, 32'd0);
        check("midscan_arc_key", {8'd0, bus0.arc_key}, 32'h1E45F0);
        check("midscan_pt_addr", {24'd0, bus0.pt_addr}, 32'd0);

        // arc4 still busy: arc_en waits for arc_rdy and lasts one cycle
        good_key = 24'h1E45F0;
        block0 = 1'b1;
        en0 = 1'b1;
        @(posedge clk);
        #1;
        en0 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("busy_hold_arc_en", {31'd0, bus0.arc_en}, 32'd0);
        end
        block0 = 1'b0;
        @(posedge clk);
        #1;
        check("busy_release_arc_en", {31'd0, bus0.arc_en}, 32'd1);
        @(posedge clk);
        #1;
        check("busy_single_arc_en",  {31'd0, bus0.arc_en}, 32'd0);
        wait_rdy(0, "busy");
        check("busy_key", {8'd0, key0}, 32'h1E45F0);
        check("busy_kv",  {31'd0, kv0}, 32'd1);

        check("arc_en_never_double", dbl0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
